// File: rtl/custom_logic_pipe_unit_pkg.sv
// Shared definitions for the custom-logic execute pipe: default widths,
// funct3 opcode encoding and the per-stage record layout.
package custom_logic_pipe_unit_pkg;

  localparam int DATA_W_DEF    = 32;
  localparam int STAGES_DEF    = 3;
  localparam int SPECTAG_W_DEF = 5;
  localparam int RRF_W_DEF     = 6;

  // funct7 bit that inverts the final result.
  localparam int FUNCT7_INV_BIT = 5;

  typedef enum logic [2:0] {
    OP_MIN  = 3'd0,  // signed min
    OP_MAX  = 3'd1,  // signed max
    OP_POPC = 3'd2,  // population count
    OP_CLZ  = 3'd3,  // count leading zeros
    OP_BREV = 3'd4,  // byte reverse
    OP_ROTR = 3'd5,  // rotate right
    OP_ANDN = 3'd6,  // A & ~B
    OP_MAXU = 3'd7   // unsigned max
  } op_e;

  // Stage record at the default widths; the top re-declares the same layout
  // at its own parameter widths.
  typedef struct packed {
    logic                     valid;
    logic                     specbit;
    logic [SPECTAG_W_DEF-1:0] spectag;
    logic [RRF_W_DEF-1:0]     rrftag;
    logic                     dstval;
    logic [DATA_W_DEF-1:0]    data;
  } stage_t;

endpackage

// File: rtl/custom_logic_alu.sv
// Combinational evaluator for the custom-logic ops: selects one of eight
// bit-manipulation results by funct3 and optionally inverts it.
module custom_logic_alu
  import custom_logic_pipe_unit_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        funct3,
  input  logic              invert,
  output logic [DATA_W-1:0] data
);

  localparam int SH_W = $clog2(DATA_W);

  op_e                 op;
  logic [DATA_W-1:0]   popc;
  logic [DATA_W-1:0]   clz;
  logic                found;
  logic [DATA_W-1:0]   brev;
  logic [2*DATA_W-1:0] rot;
  logic [DATA_W-1:0]   res;

  assign op = op_e'(funct3);

  // Evaluate all candidate results, then pick one by opcode.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    popc  = '0;
    clz   = '0;
    found = 1'b0;
    brev  = '0;
    res   = '0;

    for (int i = 0; i < DATA_W; i++) begin
      popc = popc + DATA_W'(a[i]);
    end

    // Counts down from the MSB until the first one; all-zero gives DATA_W.
    for (int i = DATA_W - 1; i >= 0; i--) begin
      if (!found) begin
        if (a[i]) found = 1'b1;
        else      clz   = clz + DATA_W'(1);
      end
    end

    for (int i = 0; i < DATA_W / 8; i++) begin
      brev[8*i +: 8] = a[DATA_W-8-8*i +: 8];
    end

    // Shifting a doubled copy right leaves the rotation in the low half.
    rot = {a, a} >> b[SH_W-1:0];

    case (op)
      OP_MIN:  res = ($signed(a) < $signed(b)) ? a : b;
      OP_MAX:  res = ($signed(a) < $signed(b)) ? b : a;
      OP_POPC: res = popc;
      OP_CLZ:  res = clz;
      OP_BREV: res = brev;
      OP_ROTR: res = rot[DATA_W-1:0];
      OP_ANDN: res = a & ~b;
      OP_MAXU: res = (a < b) ? b : a;
      default: res = '0;
    endcase

    data = invert ? ~res : res;
  end

endmodule

// File: rtl/custom_logic_pipe_unit.sv
// Pipelined custom-instruction unit for the custom-logic execute slot.
// The op is evaluated at entry and carried through STAGES registers while
// branch speculation kills or retires tag bits in every stage.
// Optional feature macro: CUSTOM_LOGIC_STALL_EN adds result_ready
// back-pressure; without it the pipe always advances and busy is 0.
module custom_logic_pipe_unit
  import custom_logic_pipe_unit_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int STAGES    = STAGES_DEF,
  parameter int SPECTAG_W = SPECTAG_W_DEF,
  parameter int RRF_W     = RRF_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 issue,
  input  logic [DATA_W-1:0]    ex_src1,
  input  logic [DATA_W-1:0]    ex_src2,
  input  logic [DATA_W-1:0]    imm,
  input  logic                 src_b_sel,
  input  logic [2:0]           funct3,
  input  logic [6:0]           funct7,
  input  logic [RRF_W-1:0]     rrftag,
  input  logic                 dstval,
  input  logic [SPECTAG_W-1:0] spectag,
  input  logic                 specbit,
  input  logic                 prmiss,
  input  logic [SPECTAG_W-1:0] prmiss_mask,
  input  logic                 prsuccess,
  input  logic [SPECTAG_W-1:0] prsuccess_tag,
`ifdef CUSTOM_LOGIC_STALL_EN
  input  logic                 result_ready,
`endif
  output logic                 busy,
  output logic                 result_valid,
  output logic [DATA_W-1:0]    result,
  output logic [RRF_W-1:0]     result_rrftag,
  output logic                 result_dstval
);

  typedef struct packed {
    logic                 valid;
    logic                 specbit;
    logic [SPECTAG_W-1:0] spectag;
    logic [RRF_W-1:0]     rrftag;
    logic                 dstval;
    logic [DATA_W-1:0]    data;
  } stage_rec_t;

  stage_rec_t        stg [1:STAGES];
  stage_rec_t        entry;
  logic [DATA_W-1:0] alu_data;
  logic              advance;
  logic              unused_funct7;

  // Only the invert bit of funct7 has meaning here.
  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  custom_logic_alu #(.DATA_W(DATA_W)) u_alu (
    .a      (ex_src1),
    .b      (src_b_sel ? imm : ex_src2),
    .funct3 (funct3),
    .invert (funct7[FUNCT7_INV_BIT]),
    .data   (alu_data)
  );

  // Kill is judged on the incoming tags before any retirement clears them.
  function automatic stage_rec_t resolve(input stage_rec_t s);
    stage_rec_t r;
    r = s;
    if (prmiss && s.specbit && |(s.spectag & prmiss_mask)) r.valid = 1'b0;
    if (prsuccess) begin
      r.spectag = s.spectag & ~prsuccess_tag;
      if (r.spectag == '0) r.specbit = 1'b0;
    end
    return r;
  endfunction

`ifdef CUSTOM_LOGIC_STALL_EN
  assign advance = !stg[STAGES].valid || result_ready;
`else
  assign advance = 1'b1;
`endif
  assign busy = !advance;

  // Assemble the record for the op entering stage 1.
  always_comb begin
    entry.valid   = issue && !busy;
    entry.specbit = specbit;
    entry.spectag = spectag;
    entry.rrftag  = rrftag;
    entry.dstval  = dstval;
    entry.data    = alu_data;
  end

  // Shift the pipe forward, or hold it while still applying kill/retire.
  always_ff @(posedge clk) begin
    // NOTE: all stage records are cleared so the outputs read zero after reset.
    if (reset) begin
      for (int i = 1; i <= STAGES; i++) stg[i] <= '0;
    end else if (advance) begin
      // NOTE: non-blocking updates let each stage read its predecessor's old value.
      stg[1] <= resolve(entry);
      for (int i = 2; i <= STAGES; i++) stg[i] <= resolve(stg[i-1]);
    end else begin
      for (int i = 1; i <= STAGES; i++) stg[i] <= resolve(stg[i]);
    end
  end

  assign result_valid  = stg[STAGES].valid;
  assign result        = stg[STAGES].data;
  assign result_rrftag = stg[STAGES].rrftag;
  assign result_dstval = stg[STAGES].dstval;

endmodule

// File: tb/tb_custom_logic_pipe_unit.sv
// Scoreboard bench for custom_logic_pipe_unit: the driver queues expected
// results at issue, an independent monitor pops and compares on every
// presented result.
module tb_custom_logic_pipe_unit;

  localparam int DW = 32;
  localparam int ST = 3;
  localparam int SW = 5;
  localparam int RW = 6;

  logic          clk;
  logic          reset;
  logic          issue;
  logic [DW-1:0] ex_src1, ex_src2, imm;
  logic          src_b_sel;
  logic [2:0]    funct3;
  logic [6:0]    funct7;
  logic [RW-1:0] rrftag;
  logic          dstval;
  logic [SW-1:0] spectag;
  logic          specbit;
  logic          prmiss;
  logic [SW-1:0] prmiss_mask;
  logic          prsuccess;
  logic [SW-1:0] prsuccess_tag;
  logic          result_ready;
  logic          busy;
  logic          result_valid;
  logic [DW-1:0] result;
  logic [RW-1:0] result_rrftag;
  logic          result_dstval;

  custom_logic_pipe_unit #(.DATA_W(DW), .STAGES(ST), .SPECTAG_W(SW), .RRF_W(RW)) dut (
    .clk           (clk),
    .reset         (reset),
    .issue         (issue),
    .ex_src1       (ex_src1),
    .ex_src2       (ex_src2),
    .imm           (imm),
    .src_b_sel     (src_b_sel),
    .funct3        (funct3),
    .funct7        (funct7),
    .rrftag        (rrftag),
    .dstval        (dstval),
    .spectag       (spectag),
    .specbit       (specbit),
    .prmiss        (prmiss),
    .prmiss_mask   (prmiss_mask),
    .prsuccess     (prsuccess),
    .prsuccess_tag (prsuccess_tag),
`ifdef CUSTOM_LOGIC_STALL_EN
    .result_ready  (result_ready),
`endif
    .busy          (busy),
    .result_valid  (result_valid),
    .result        (result),
    .result_rrftag (result_rrftag),
    .result_dstval (result_dstval)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] data;
    logic [RW-1:0] tag;
    logic          dst;
    int            cyc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   lat_chk = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, wanted 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: every accepted result must match the oldest queued expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset && result_valid && result_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_result: got tag %0d data 0x%0h, wanted no result",
                 result_rrftag, result);
      end else begin
        e = sb.pop_front();
        check("result", result, e.data);
        check("rrftag", 32'(result_rrftag), 32'(e.tag));
        check("dstval", 32'(result_dstval), 32'(e.dst));
        if (e.cyc >= 0) check("latency", cyc, e.cyc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    issue       = 1'b0;
    prmiss      = 1'b0;
    prmiss_mask = '0;
    prsuccess   = 1'b0;
    prsuccess_tag = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Drive one op for one cycle; queue its expected result if it should survive.
  task automatic drive(input logic [2:0] f3, input logic [6:0] f7,
                       input logic [DW-1:0] a, input logic [DW-1:0] b, input logic sel,
                       input logic [RW-1:0] tag, input logic [SW-1:0] st, input logic sbit,
                       input bit keep, input logic [DW-1:0] expv);
    exp_t e;
    issue     = 1'b1;
    funct3    = f3;
    funct7    = f7;
    ex_src1   = a;
    src_b_sel = sel;
    imm       = sel ? b : ~b;
    ex_src2   = sel ? ~b : b;
    rrftag    = tag;
    dstval    = tag[0];
    spectag   = st;
    specbit   = sbit;
    if (keep) begin
      e.data = expv;
      e.tag  = tag;
      e.dst  = tag[0];
      e.cyc  = lat_chk ? cyc + ST : -1;
      sb.push_back(e);
    end
    step();
  endtask

  initial begin
    reset = 1'b1; issue = 1'b1; ex_src1 = 32'h1; ex_src2 = 32'h2; imm = 32'h3;
    src_b_sel = 1'b0; funct3 = 3'd2; funct7 = 7'h0; rrftag = 6'd63; dstval = 1'b1;
    spectag = '0; specbit = 1'b0; prmiss = 1'b0; prmiss_mask = '0;
    prsuccess = 1'b0; prsuccess_tag = '0; result_ready = 1'b1;

    // Reset held with issue asserted: everything stays zero.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("reset_valid", 32'(result_valid), 32'h0);
      check("reset_result", result, 32'h0);
      check("reset_rrftag", 32'(result_rrftag), 32'h0);
      check("reset_dstval", 32'(result_dstval), 32'h0);
      check("reset_busy", 32'(busy), 32'h0);
    end
    @(posedge clk); #1;
    reset = 1'b0; issue = 1'b0;
    idle(ST + 2);
    @(negedge clk);
    check("post_reset_valid", 32'(result_valid), 32'h0);
    @(posedge clk); #1;

    // Back-to-back ops, one per cycle.
    drive(3'd3, 7'h00, 32'h00F00000, 32'h0,        1'b0, 6'd1,  5'b0, 1'b0, 1, 32'd8);
    drive(3'd5, 7'h00, 32'h00000001, 32'h1,        1'b1, 6'd2,  5'b0, 1'b0, 1, 32'h80000000);
    drive(3'd3, 7'h00, 32'h0,        32'h0,        1'b0, 6'd3,  5'b0, 1'b0, 1, 32'd32);
    drive(3'd2, 7'h00, 32'hFFFFFFFF, 32'h0,        1'b0, 6'd4,  5'b0, 1'b0, 1, 32'd32);
    drive(3'd0, 7'h00, 32'h80000000, 32'h1,        1'b0, 6'd5,  5'b0, 1'b0, 1, 32'h80000000);
    drive(3'd6, 7'h20, 32'h00001234, 32'h00001234, 1'b0, 6'd6,  5'b0, 1'b0, 1, 32'hFFFFFFFF);
    drive(3'd1, 7'h00, 32'h80000000, 32'h1,        1'b1, 6'd7,  5'b0, 1'b0, 1, 32'h1);
    drive(3'd4, 7'h00, 32'h11223344, 32'h0,        1'b0, 6'd8,  5'b0, 1'b0, 1, 32'h44332211);
    drive(3'd7, 7'h00, 32'h80000000, 32'h1,        1'b0, 6'd9,  5'b0, 1'b0, 1, 32'h80000000);
    drive(3'd2, 7'h00, 32'h0F0F0001, 32'h0,        1'b0, 6'd10, 5'b0, 1'b0, 1, 32'd9);
    drive(3'd5, 7'h00, 32'h12345678, 32'h00000108, 1'b0, 6'd11, 5'b0, 1'b0, 1, 32'h78123456);
    drive(3'd6, 7'h00, 32'hFF00FF00, 32'h0F0F0F0F, 1'b1, 6'd12, 5'b0, 1'b0, 1, 32'hF000F000);
    drive(3'd0, 7'h1F, 32'h00000005, 32'hFFFFFFFD, 1'b0, 6'd13, 5'b0, 1'b0, 1, 32'hFFFFFFFD);
    drive(3'd2, 7'h20, 32'h0,        32'h0,        1'b0, 6'd14, 5'b0, 1'b0, 1, 32'hFFFFFFFF);
    idle(ST + 2);

    // Mispredict: only the op depending on the missed tag is squashed.
    drive(3'd2, 7'h00, 32'h3, 32'h0, 1'b0, 6'd20, 5'b00010, 1'b1, 0, 32'd2);
    drive(3'd2, 7'h00, 32'h7, 32'h0, 1'b0, 6'd21, 5'b00001, 1'b1, 1, 32'd3);
    prmiss = 1'b1; prmiss_mask = 5'b00010;
    drive(3'd2, 7'h00, 32'hF, 32'h0, 1'b0, 6'd22, 5'b00010, 1'b1, 0, 32'd4);
    prmiss = 1'b1; prmiss_mask = 5'b00010;
    drive(3'd2, 7'h00, 32'h1, 32'h0, 1'b0, 6'd23, 5'b00010, 1'b0, 1, 32'd1);
    drive(3'd2, 7'h00, 32'h3F, 32'h0, 1'b0, 6'd24, 5'b00010, 1'b1, 0, 32'd6);
    prmiss = 1'b1; prmiss_mask = 5'b00010;
    step();
    idle(ST + 2);

    // Tag retirement, and kill seen on pre-clear tags.
    drive(3'd2, 7'h00, 32'h1F, 32'h0, 1'b0, 6'd30, 5'b00100, 1'b1, 1, 32'd5);
    prsuccess = 1'b1; prsuccess_tag = 5'b00100;
    step();
    prmiss = 1'b1; prmiss_mask = 5'b00100;
    step();
    prmiss = 1'b1; prmiss_mask = 5'b01000; prsuccess = 1'b1; prsuccess_tag = 5'b01000;
    drive(3'd2, 7'h00, 32'h3, 32'h0, 1'b0, 6'd31, 5'b01000, 1'b1, 0, 32'd2);
    prsuccess = 1'b1; prsuccess_tag = 5'b10000;
    drive(3'd2, 7'h00, 32'h7F, 32'h0, 1'b0, 6'd32, 5'b10000, 1'b1, 1, 32'd7);
    prmiss = 1'b1; prmiss_mask = 5'b10000;
    step();
    drive(3'd2, 7'h00, 32'h1, 32'h0, 1'b0, 6'd33, 5'b00110, 1'b1, 0, 32'd1);
    prsuccess = 1'b1; prsuccess_tag = 5'b00100;
    step();
    prmiss = 1'b1; prmiss_mask = 5'b00010;
    step();
    idle(ST + 2);

    // Reset mid-operation drops in-flight ops.
    drive(3'd2, 7'h00, 32'h1, 32'h0, 1'b0, 6'd40, 5'b0, 1'b0, 0, 32'd1);
    drive(3'd2, 7'h00, 32'h3, 32'h0, 1'b0, 6'd41, 5'b0, 1'b0, 0, 32'd2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    check("mid_reset_valid", 32'(result_valid), 32'h0);
    @(posedge clk); #1;
    idle(ST + 2);

`ifdef CUSTOM_LOGIC_STALL_EN
    // Back-pressure: fill the pipe, hold, then drain in order.
    lat_chk = 1'b0;
    result_ready = 1'b0;
    drive(3'd2, 7'h00, 32'h1, 32'h0, 1'b0, 6'd50, 5'b0, 1'b0, 1, 32'd1);
    drive(3'd2, 7'h00, 32'h3, 32'h0, 1'b0, 6'd51, 5'b0, 1'b0, 1, 32'd2);
    drive(3'd2, 7'h00, 32'h7, 32'h0, 1'b0, 6'd52, 5'b0, 1'b0, 1, 32'd3);
    for (int i = 0; i < 4; i++) begin
      issue = 1'b1; rrftag = 6'd53; ex_src1 = 32'hFF;
      @(negedge clk);
      check("stall_busy", 32'(busy), 32'h1);
      check("stall_valid", 32'(result_valid), 32'h1);
      check("stall_result", result, 32'd1);
      check("stall_rrftag", 32'(result_rrftag), 32'd50);
      @(posedge clk); #1;
    end
    issue = 1'b0;
    result_ready = 1'b1;
    idle(ST + 2);
    lat_chk = 1'b1;
`endif

    idle(ST + 3);
    check("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
